// File: rtl/decoder_nto2n_reg.sv
// decoder_nto2n_reg: registered N-to-M one-hot decoder with a valid/ready command port.
// Level mode holds the decoded line until it is retargeted or disabled. Pulse mode drives
// the line for HOLD_CYCLES cycles and then returns to idle.
// Optional feature: define DECODER_OOR_ERR_EN to get a sticky out-of-range error flag.
// Without it err is tied low and out-of-range commands are dropped silently.
module decoder_nto2n_reg #(
    parameter int unsigned SEL_W       = 2,
    parameter int unsigned NUM_OUT     = 4,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_pulse,
    output logic [NUM_OUT-1:0] out,
    output logic               active,
    output logic [SEL_W-1:0]   sel_q,
    output logic               err
);

    // Counter holds HOLD_CYCLES-1 down to 0; keep at least one bit for HOLD_CYCLES=1.
    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHoldLvl = 2'd1,
        StHoldPls = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_d;
    logic [NUM_OUT-1:0] out_d;
    logic               active_d;
    logic               accept;
    logic               in_range;
    logic               oor_accept;

    // Ready is suppressed during reset and while a pulse is running.
    assign in_ready   = ~rst & en & (state_q != StHoldPls);
    assign accept     = en & in_valid & in_ready;
    assign in_range   = (32'(in_sel) < NUM_OUT);
    assign oor_accept = accept & ~in_range;

    // State, counter, select and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sel_q   <= '0;
            out     <= '0;
            active  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            out     <= out_d;
            active  <= active_d;
        end
    end

    // Next-state, counter and select update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        if (!en) begin
            // Disable cancels everything, including an in-progress pulse.
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle, StHoldLvl: begin
                    if (accept) begin
                        if (in_range) begin
                            sel_d = in_sel;
                            if (in_pulse) begin
                                state_d = StHoldPls;
                                cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                            end else begin
                                state_d = StHoldLvl;
                                cnt_d   = '0;
                            end
                        end else begin
                            // Out-of-range: drop to idle, keep the last good select.
                            state_d = StIdle;
                            cnt_d   = '0;
                        end
                    end
                end
                StHoldPls: begin
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Decoded outputs are derived from the next state so they register alongside it.
    always_comb begin
        out_d    = '0;
        active_d = (state_d != StIdle);
        if (state_d != StIdle) begin
            for (int unsigned i = 0; i < NUM_OUT; i++) begin
                out_d[i] = (32'(sel_d) == i);
            end
        end
    end

`ifdef DECODER_OOR_ERR_EN
    logic err_q;

    // Sticky error: set by any out-of-range accept, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (oor_accept) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_oor;
    assign unused_oor = oor_accept;
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_nto2n_reg.sv
// Scoreboard bench for decoder_nto2n_reg: the driver pushes expected values from a
// behavioural model, a separate monitor pops and compares against the DUT.
module tb_decoder_nto2n_reg;

    localparam int SEL_W = 3;
    localparam int NUM_OUT = 5;
    localparam int HOLD_CYCLES = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [SEL_W-1:0]   in_sel = '0;
    logic               in_pulse = 1'b0;
    logic [NUM_OUT-1:0] out;
    logic               active;
    logic [SEL_W-1:0]   sel_q;
    logic               err;

    decoder_nto2n_reg #(
        .SEL_W      (SEL_W),
        .NUM_OUT    (NUM_OUT),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sel  (in_sel),
        .in_pulse(in_pulse),
        .out     (out),
        .active  (active),
        .sel_q   (sel_q),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ready;
        logic [31:0] out;
        logic       active;
        logic [31:0] sel;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    // Behavioural model: which line is lit (-1 = none), pulse cycles still to show.
    int   m_line = -1;
    int   m_left = 0;
    int   m_sel = 0;
    logic m_err = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // One cycle of stimulus; expectations computed from the behavioural rules.
    task automatic step(input logic r, input logic e, input logic v, input int s,
                        input logic p);
        exp_t it;
        logic rdy;
        @(negedge clk);
        rst      = r;
        en       = e;
        in_valid = v;
        in_sel   = SEL_W'(s);
        in_pulse = p;
        rdy      = !r && e && (m_left == 0);
        it.ready = rdy;
        if (r) begin
            m_line = -1; m_left = 0; m_sel = 0; m_err = 1'b0;
        end else if (!e) begin
            m_line = -1; m_left = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) m_line = -1;
        end else if (v && rdy) begin
            if (s < NUM_OUT) begin
                m_line = s;
                m_sel  = s;
                m_left = p ? HOLD_CYCLES : 0;
            end else begin
                m_line = -1;
                m_left = 0;
`ifdef DECODER_OOR_ERR_EN
                m_err  = 1'b1;
`endif
            end
        end
        it.out    = (m_line < 0) ? 32'd0 : (32'd1 << m_line);
        it.active = (m_line >= 0);
        it.sel    = 32'(m_sel);
        it.err    = m_err;
        q.push_back(it);
    endtask

    // Monitor: ready is checked mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() != 0) begin
                it = q.pop_front();
                chk("in_ready", 32'(in_ready), 32'(it.ready));
                @(posedge clk);
                #1;
                chk("out", 32'(out), it.out);
                chk("active", 32'(active), 32'(it.active));
                chk("sel_q", 32'(sel_q), it.sel);
                chk("err", 32'(err), 32'(it.err));
            end
        end
    end

    initial begin
        // Reset with en and in_valid high.
        step(1, 1, 1, 3, 0);
        step(1, 1, 1, 2, 1);
        step(0, 1, 0, 0, 0);
        // Level mode, every in-range line, back to back.
        for (int s = 0; s < NUM_OUT; s++) step(0, 1, 1, s, 0);
        step(0, 1, 0, 0, 0);
        // Pulse on line 2; valid held during the pulse must be ignored until idle.
        step(0, 1, 1, 2, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);
        // Disable at the second pulse cycle; no resumption after re-enable.
        step(0, 1, 1, 3, 1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        // Out-of-range from level on line 1; err stickiness across en low.
        step(0, 1, 1, 1, 0);
        step(0, 1, 1, 6, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 2, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 7, 1);
        // Reset while counter=2 mid-pulse, then a full pulse.
        step(0, 1, 1, 4, 1);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 90) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0);
        end
        step(0, 1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
